saa_sample_accumulator: RTL and testbench
=========================================

Name: saa_sample_accumulator

Overview:
- Upstream stage of the audio mixer. Sums the six SAA1099-style channel amplitude contributions into one 8-bit left sample and one 8-bit right sample.
- The sum is time-multiplexed: one channel per clock, started by a sample-rate tick.
- Results are presented as registered saa_left / saa_right. They hold steady between updates, so the mixer can sample them on any clock.

Parameters:
- NCHAN, 6: number of channels accumulated. Legal range 1..8. Accumulator width is sized for NCHAN*15.
- GAIN_SHIFT, 1: left shift applied to each raw channel sum before saturation to 8 bits. Legal range 0..4.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sample_tick  in  1  one-clock pulse that starts an accumulation pass
- sound_en  in  1  global sound enable; when 0, all contributions are zero
- chan_on  in  NCHAN  per-channel gated tone/noise output bit
- amp_l  in  4*NCHAN  left amplitude; channel i occupies [4i+3:4i]
- amp_r  in  4*NCHAN  right amplitude; channel i occupies [4i+3:4i]
- saa_left  out  8  scaled, saturated left sample
- saa_right  out  8  scaled, saturated right sample
- sample_valid  out  1  one-clock pulse when saa_left / saa_right update
- busy  out  1  high while a pass is in progress
- overrun  out  1  one-clock pulse when sample_tick arrives while busy

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: saa_left=0, saa_right=0, sample_valid=0, busy=0, overrun=0, accumulators=0, channel index=0, state=IDLE.
- Reset overrides everything, including a pass in progress. The pass is abandoned, and no sample_valid is produced for it.
- IDLE state:
  - On clock edge E0 with sample_tick=1, snapshot sound_en, chan_on, amp_l and amp_r into internal registers.
  - At the same edge, clear both accumulators, set index=0, go to ACC, set busy=1.
  - Input changes after E0 do not affect the pass.
- ACC state, one channel per clock:
  - At edge Ek (k=1..NCHAN), channel k-1 is added to each accumulator.
  - A channel contributes its snapshot amplitude when snap_sound_en & snap_chan_on[k-1]; otherwise it contributes 0.
  - After channel NCHAN-1 is added, go to OUT.
- OUT state, at edge E(NCHAN+1):
  - saa_left = min(acc_l << GAIN_SHIFT, 255); saa_right = the same with acc_r.
  - Saturation is computed at full width; no truncation before the compare.
  - sample_valid=1 for exactly this cycle. busy=0 at the same edge. Return to IDLE.
- Latency:
  - Outputs update NCHAN+1 clocks after the edge that accepts the tick (7 clocks at default settings).
  - Minimum tick spacing is NCHAN+2 clocks.
  - A tick in the same cycle as sample_valid, in OUT state, is not accepted and counts as an overrun.
- sample_tick while busy=1:
  - The tick is ignored and the pass continues unchanged.
  - overrun pulses for one clock, at the edge following the ignored tick.
- Between passes, saa_left and saa_right hold their last values. sample_valid=0 at all times outside OUT.
- sound_en=0 at snapshot: the pass still runs and produces sample_valid, with saa_left=saa_right=0.
- Arithmetic:
  - Unsigned throughout. Accumulator width is ceil(log2(NCHAN*15+1)) bits; 7 bits for the default.
  - Shifted-value width is accumulator width plus GAIN_SHIFT.
- Fixed 8-bit output: with the downstream beeper maximum of 127, the combined sample fits in the mixer's 9-bit path.

Test Plan:
- Reset then idle 20 clocks -> saa_left=saa_right=0, no sample_valid, busy=0.
- All chan_on=1, sound_en=1, all amp_l=15, all amp_r=3, GAIN_SHIFT=1; tick at cycle T -> sample_valid at T+7 with saa_left=180, saa_right=36. busy high T+1..T+6.
- Same inputs with GAIN_SHIFT=2 -> saa_left saturates to 255 (raw 360), saa_right=72.
- chan_on=6'b000101, amp_l channel0=4, channel2=9, others=15 -> saa_left=26. Change amp_l to all 0 at T+2 -> result unchanged (snapshot).
- Second tick at T+3 -> overrun pulse at T+4, single sample_valid at T+7. Tick at T+7 -> also overrun, not accepted.
- reset asserted at T+4 mid-pass -> no sample_valid, outputs 0, busy=0. A next tick behaves as a fresh pass. Separately: sound_en=0 at tick -> valid pulse with both outputs 0.

Source files
------------

// File: rtl/saa_sample_accumulator_if.sv
// saa_sample_accumulator_if: tick/amplitude inputs and sample outputs of the channel accumulator
interface saa_sample_accumulator_if #(parameter int NCHAN = 6);
  logic sample_tick;
  logic sound_en;
  logic [NCHAN-1:0] chan_on;
  logic [4*NCHAN-1:0] amp_l;
  logic [4*NCHAN-1:0] amp_r;
  logic [7:0] saa_left;
  logic [7:0] saa_right;
  logic sample_valid;
  logic busy;
  logic overrun;
  modport master (
    output sample_tick, sound_en, chan_on, amp_l, amp_r,
    input saa_left, saa_right, sample_valid, busy, overrun
  );
  modport slave (
    input sample_tick, sound_en, chan_on, amp_l, amp_r,
    output saa_left, saa_right, sample_valid, busy, overrun
  );
endinterface

// File: rtl/saa_sample_accumulator.sv
// saa_sample_accumulator: time-multiplexed sum of channel amplitudes into saturated 8-bit left/right samples
module saa_sample_accumulator #(
  parameter int NCHAN = 6,
  parameter int GAIN_SHIFT = 1
) (
  input logic clk,
  input logic reset,
  saa_sample_accumulator_if.slave bus
);
  localparam int AW = $clog2(NCHAN * 15 + 1);
  localparam int SW = (AW + GAIN_SHIFT > 8) ? AW + GAIN_SHIFT : 8;
  localparam int IW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [AW-1:0] acc_l, acc_r;
  logic snap_en;
  logic [NCHAN-1:0] snap_on;
  logic [4*NCHAN-1:0] snap_l, snap_r;
  logic on;
  logic [3:0] lane_l, lane_r;
  logic [SW-1:0] sh_l, sh_r;
  assign on = snap_en & snap_on[idx];
  assign lane_l = on ? snap_l[4*idx +: 4] : 4'd0;
  assign lane_r = on ? snap_r[4*idx +: 4] : 4'd0;
  assign sh_l = SW'(acc_l) << GAIN_SHIFT;
  assign sh_r = SW'(acc_r) << GAIN_SHIFT;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (bus.sample_tick ? ACC : IDLE)
            : state == ACC ? (idx == IW'(NCHAN - 1) ? OUT : ACC)
            : IDLE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
      acc_l <= '0;
      acc_r <= '0;
      snap_en <= 1'b0;
      snap_on <= '0;
      snap_l <= '0;
      snap_r <= '0;
      bus.saa_left <= 8'd0;
      bus.saa_right <= 8'd0;
      bus.sample_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      bus.overrun <= bus.sample_tick & bus.busy;
      if (state == IDLE && bus.sample_tick) begin
        snap_en <= bus.sound_en;
        snap_on <= bus.chan_on;
        snap_l <= bus.amp_l;
        snap_r <= bus.amp_r;
        acc_l <= '0;
        acc_r <= '0;
        idx <= '0;
        bus.busy <= 1'b1;
      end
      if (state == ACC) begin
        acc_l <= acc_l + AW'(lane_l);
        acc_r <= acc_r + AW'(lane_r);
        idx <= idx + 1'b1;
      end
      if (state == OUT) begin
        bus.saa_left <= sh_l > SW'(255) ? 8'hff : sh_l[7:0];
        bus.saa_right <= sh_r > SW'(255) ? 8'hff : sh_r[7:0];
        bus.sample_valid <= 1'b1;
        bus.busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_saa_sample_accumulator.sv
// tb_saa_sample_accumulator: directed checks of two accumulators sharing inputs, GAIN_SHIFT 1 and 2
module tb_saa_sample_accumulator;
  logic clk = 1'b0;
  logic reset;
  int ncmp = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  saa_sample_accumulator_if #(.NCHAN(6)) b1 ();
  saa_sample_accumulator_if #(.NCHAN(6)) b2 ();
  assign b2.sample_tick = b1.sample_tick;
  assign b2.sound_en = b1.sound_en;
  assign b2.chan_on = b1.chan_on;
  assign b2.amp_l = b1.amp_l;
  assign b2.amp_r = b1.amp_r;
  saa_sample_accumulator #(.NCHAN(6), .GAIN_SHIFT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  saa_sample_accumulator #(.NCHAN(6), .GAIN_SHIFT(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_pass(input string tag, input logic [7:0] l1, input logic [7:0] r1,
                          input logic [7:0] l2, input logic [7:0] r2);
    b1.sample_tick = 1'b1;
    step();
    b1.sample_tick = 1'b0;
    chk({tag, " busy E0"}, b1.busy, 1);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk({tag, " busy Ek"}, b1.busy, 1);
      chk({tag, " valid Ek"}, b1.sample_valid, 0);
    end
    step();
    chk({tag, " valid"}, b1.sample_valid, 1);
    chk({tag, " busy end"}, b1.busy, 0);
    chk({tag, " left g1"}, b1.saa_left, l1);
    chk({tag, " right g1"}, b1.saa_right, r1);
    chk({tag, " left g2"}, b2.saa_left, l2);
    chk({tag, " right g2"}, b2.saa_right, r2);
    chk({tag, " valid g2"}, b2.sample_valid, 1);
    step();
    chk({tag, " valid drop"}, b1.sample_valid, 0);
    chk({tag, " left hold"}, b1.saa_left, l1);
    chk({tag, " right hold"}, b1.saa_right, r1);
  endtask
  initial begin
    reset = 1'b1;
    b1.sample_tick = 1'b0;
    b1.sound_en = 1'b0;
    b1.chan_on = '0;
    b1.amp_l = '0;
    b1.amp_r = '0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle valid", b1.sample_valid, 0);
      chk("idle busy", b1.busy, 0);
      chk("idle overrun", b1.overrun, 0);
    end
    chk("idle left", b1.saa_left, 0);
    chk("idle right", b1.saa_right, 0);
    b1.sound_en = 1'b1;
    b1.chan_on = 6'b111111;
    b1.amp_l = 24'hFFFFFF;
    b1.amp_r = 24'h333333;
    run_pass("full", 8'd180, 8'd36, 8'd255, 8'd72);
    b1.chan_on = 6'b000101;
    b1.amp_l = 24'hFFF9F4;
    b1.sample_tick = 1'b1;
    step();
    b1.sample_tick = 1'b0;
    step();
    b1.amp_l = '0;
    step();
    b1.sample_tick = 1'b1;
    step();
    b1.sample_tick = 1'b0;
    chk("overrun mid", b1.overrun, 1);
    chk("busy mid", b1.busy, 1);
    step();
    chk("overrun drop", b1.overrun, 0);
    step();
    step();
    chk("valid before out", b1.sample_valid, 0);
    b1.sample_tick = 1'b1;
    step();
    b1.sample_tick = 1'b0;
    chk("snap valid", b1.sample_valid, 1);
    chk("snap left g1", b1.saa_left, 26);
    chk("snap right g1", b1.saa_right, 12);
    chk("snap left g2", b2.saa_left, 52);
    chk("snap right g2", b2.saa_right, 24);
    chk("overrun at out", b1.overrun, 1);
    chk("busy after out", b1.busy, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("no accept valid", b1.sample_valid, 0);
      chk("no accept busy", b1.busy, 0);
    end
    b1.chan_on = 6'b111111;
    b1.amp_l = 24'hFFFFFF;
    b1.amp_r = 24'h333333;
    b1.sample_tick = 1'b1;
    step();
    b1.sample_tick = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst valid", b1.sample_valid, 0);
    chk("rst left", b1.saa_left, 0);
    chk("rst right", b1.saa_right, 0);
    chk("rst busy", b1.busy, 0);
    chk("rst overrun", b1.overrun, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post rst valid", b1.sample_valid, 0);
      chk("post rst busy", b1.busy, 0);
    end
    b1.chan_on = 6'b111000;
    b1.amp_l = 24'h123456;
    b1.amp_r = 24'hABCDEF;
    run_pass("fresh", 8'd12, 8'd66, 8'd24, 8'd132);
    b1.sound_en = 1'b0;
    b1.chan_on = 6'b111111;
    b1.amp_l = 24'hFFFFFF;
    b1.amp_r = 24'hFFFFFF;
    run_pass("mute", 8'd0, 8'd0, 8'd0, 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
